// File: rtl/clk_divider_prog.sv
// Multi-channel run-time programmable clock divider. Divisor/mode writes are
// shadowed per channel and take effect only at a period boundary.
module clk_divider_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              wr_mode,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [DIV_W-1:0]  cnt_r    [NUM_CH];
  logic [DIV_W-1:0]  cnt_s    [NUM_CH];
  logic [DIV_W-1:0]  div_r    [NUM_CH];
  logic [DIV_W-1:0]  div_s    [NUM_CH];
  logic [DIV_W-1:0]  sh_div_r [NUM_CH];
  logic [DIV_W-1:0]  sh_div_s [NUM_CH];
  logic [NUM_CH-1:0] mode_r, mode_s, sh_mode_r, sh_mode_s;
  logic [NUM_CH-1:0] pend_r, pend_s, clk_r, clk_s, tick_r, tick_s;
  logic [NUM_CH-1:0] hit_s, tc_s, bnd_s;

  // Per-channel next state: counting, output generation and shadow application.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_s[i]     = cnt_r[i];
      div_s[i]     = div_r[i];
      sh_div_s[i]  = sh_div_r[i];
      mode_s[i]    = mode_r[i];
      sh_mode_s[i] = sh_mode_r[i];
      pend_s[i]    = pend_r[i];
      clk_s[i]     = clk_r[i];
      tick_s[i]    = 1'b0;
      bnd_s[i]     = 1'b0;
      hit_s[i]     = wr_en & (wr_ch == CH_W'(i));
      tc_s[i]      = (cnt_r[i] == div_r[i]);

      if (!ch_en[i]) begin
        // An idle channel has no period to protect, so a pending update lands next edge.
        cnt_s[i]  = {DIV_W{1'b0}};
        clk_s[i]  = 1'b0;
        tick_s[i] = 1'b0;
        bnd_s[i]  = pend_r[i];
      end else begin
        cnt_s[i] = tc_s[i] ? {DIV_W{1'b0}} : cnt_r[i] + DIV_W'(1);
        if (mode_r[i]) begin
          clk_s[i]  = 1'b0;
          tick_s[i] = tc_s[i];
          bnd_s[i]  = tc_s[i];
        end else begin
          clk_s[i]  = tc_s[i] ? ~clk_r[i] : clk_r[i];
          tick_s[i] = tc_s[i] & ~clk_r[i];
          bnd_s[i]  = tc_s[i] & clk_r[i];
        end
      end

      if (bnd_s[i]) begin
        cnt_s[i]  = {DIV_W{1'b0}};
        clk_s[i]  = 1'b0;
        pend_s[i] = 1'b0;
        if (hit_s[i]) begin
          div_s[i]     = wr_div;
          mode_s[i]    = wr_mode;
          sh_div_s[i]  = wr_div;
          sh_mode_s[i] = wr_mode;
        end else begin
          div_s[i]  = sh_div_r[i];
          mode_s[i] = sh_mode_r[i];
        end
      end else if (hit_s[i]) begin
        sh_div_s[i]  = wr_div;
        sh_mode_s[i] = wr_mode;
        pend_s[i]    = 1'b1;
      end else begin
        pend_s[i] = pend_r[i];
      end
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]    <= {DIV_W{1'b0}};
        div_r[i]    <= DIV_W'(DEFAULT_DIV);
        sh_div_r[i] <= DIV_W'(DEFAULT_DIV);
      end
      mode_r    <= {NUM_CH{1'b0}};
      sh_mode_r <= {NUM_CH{1'b0}};
      pend_r    <= {NUM_CH{1'b0}};
      clk_r     <= {NUM_CH{1'b0}};
      tick_r    <= {NUM_CH{1'b0}};
    end else begin
      cnt_r     <= cnt_s;
      div_r     <= div_s;
      sh_div_r  <= sh_div_s;
      mode_r    <= mode_s;
      sh_mode_r <= sh_mode_s;
      pend_r    <= pend_s;
      clk_r     <= clk_s;
      tick_r    <= tick_s;
    end
  end

  assign clkout  = clk_r;
  assign tick    = tick_r;
  assign pending = pend_r;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed scenarios plus random traffic, every cycle
// compared against a period-position reference model.
module tb_clk_divider_prog;
  localparam int NUM_CH      = 5;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 3;

  logic              clkin = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic              wr_mode;
  logic [NUM_CH-1:0] clkout, tick, pending;

  clk_divider_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clkin(clkin), .reset(reset), .ch_en(ch_en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_mode(wr_mode), .clkout(clkout), .tick(tick), .pending(pending)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: active/shadow config plus edges elapsed in the current period.
  int m_div [NUM_CH];
  int m_mode[NUM_CH];
  int m_sdiv[NUM_CH];
  int m_smod[NUM_CH];
  int m_k   [NUM_CH];
  logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = DEFAULT_DIV; m_mode[i] = 0;
      m_sdiv[i] = DEFAULT_DIV; m_smod[i] = 0; m_k[i] = 0;
    end
    e_clk = '0; e_tick = '0; e_pend = '0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int p, m;
        logic hit, bnd;
        hit = wr_en && (int'(wr_ch) == i);
        if (!ch_en[i]) begin
          m_k[i] = 0; e_clk[i] = 1'b0; e_tick[i] = 1'b0; bnd = e_pend[i];
        end else begin
          m_k[i]++;
          if (m_mode[i] != 0) begin
            p = m_div[i] + 1; m = m_k[i] % p;
            e_clk[i] = 1'b0; e_tick[i] = (m == 0);
          end else begin
            p = 2 * (m_div[i] + 1); m = m_k[i] % p;
            e_clk[i] = (m >= m_div[i] + 1); e_tick[i] = (m == m_div[i] + 1);
          end
          bnd = (m == 0);
        end
        if (bnd) begin
          e_pend[i] = 1'b0; m_k[i] = 0;
          if (hit) begin
            m_div[i] = int'(wr_div); m_mode[i] = int'(wr_mode);
            m_sdiv[i] = int'(wr_div); m_smod[i] = int'(wr_mode);
          end else begin
            m_div[i] = m_sdiv[i]; m_mode[i] = m_smod[i];
          end
        end else if (hit) begin
          m_sdiv[i] = int'(wr_div); m_smod[i] = int'(wr_mode); e_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    check_val("clkout", 32'(clkout), 32'(e_clk));
    check_val("tick", 32'(tick), 32'(e_tick));
    check_val("pending", 32'(pending), 32'(e_pend));
    wr_en = 1'b0;
  endtask

  task automatic write(input int ch, input int dv, input logic md);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(dv); wr_mode = md;
  endtask

  initial begin
    int hi, tk, found;
    reset = 1'b0; ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
    model_reset();
    #12;
    check_val("rst_clkout", 32'(clkout), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    reset = 1'b1;

    // Defaults on channel 0: period 10, high 5.
    ch_en = 5'b00001;
    hi = 0; tk = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      hi += int'(clkout[0]); tk += int'(tick[0]);
    end
    check_val("p1_high", 32'(hi), 32'd10);
    check_val("p1_ticks", 32'(tk), 32'd2);
    check_val("p1_others", 32'(clkout[4:1] | tick[4:1]), 32'd0);

    // Mid-period update on channel 0 waits for the falling boundary.
    for (int c = 0; c < 3; c++) step();
    write(0, 1, 1'b0);
    for (int c = 0; c < 30; c++) step();

    // Disabled channel 2 takes pulse div 2, then ticks 3, 6, 9 after enable.
    write(2, 2, 1'b1);
    for (int c = 0; c < 3; c++) step();
    ch_en[2] = 1'b1;
    tk = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (tick[2]) tk += c;
    end
    check_val("p3_tick_sum", 32'(tk), 32'd18);

    // Two writes to channel 1 before its boundary, then an out-of-range write.
    ch_en[1] = 1'b1;
    step();
    write(1, 7, 1'b0); step();
    write(1, 3, 1'b0); step();
    write(5, 9, 1'b1); step();
    write(7, 0, 1'b1); step();
    for (int c = 0; c < 30; c++) step();

    // Divs 0/1/2/3 toggle on channels 0..3, then channel 1 disabled for 3 cycles.
    ch_en = 5'b00000;
    for (int ch = 0; ch < 4; ch++) begin
      write(ch, ch, 1'b0); step();
    end
    step();
    ch_en = 5'b01111;
    for (int c = 0; c < 40; c++) step();
    ch_en[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    ch_en[1] = 1'b1;
    for (int c = 0; c < 20; c++) step();

    // Reset during a high phase with channel 0 update pending.
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (!clkout[0]) found = 1; else step();
    end
    check_val("p6_wait_low", 32'(found), 32'd1);
    write(0, 6, 1'b0);
    step();
    check_val("p6_pending", 32'(pending[0]), 32'd1);
    check_val("p6_high", 32'(clkout[0]), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_val("p6_async_clk", 32'(clkout), 32'd0);
    check_val("p6_async_pend", 32'(pending), 32'd0);
    step();
    step();
    reset = 1'b1;
    ch_en = 5'b00001;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      hi += int'(clkout[0]);
    end
    check_val("p6_default_high", 32'(hi), 32'd10);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        write(int'($urandom_range(0, 7)),
              ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 9)),
              1'($urandom));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
